jk_flop_bank: RTL

//   Parametrised bank of WIDTH JK-style flip-flops sharing one clock, one reset and one mode.

---
 rtl/jk_pkg.sv | 20 ++
 rtl/jk_flop_bank_if.sv | 29 ++
 rtl/jk_cell.sv | 42 ++++
 rtl/jk_flop_bank.sv | 81 ++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK flip-flop bank and its per-bit cell.
package jk_pkg;

  localparam int unsigned JK_MODE_W = 3;

  typedef logic [JK_MODE_W-1:0] jk_mode_t;

  localparam jk_mode_t JK_MODE_JK     = 3'd0;
  localparam jk_mode_t JK_MODE_D      = 3'd1;
  localparam jk_mode_t JK_MODE_T      = 3'd2;
  localparam jk_mode_t JK_MODE_SR     = 3'd3;
  localparam jk_mode_t JK_MODE_CNT_UP = 3'd4;
  localparam jk_mode_t JK_MODE_CNT_DN = 3'd5;

  // Codes 6 and 7 are reserved; the bank treats them as hold.
  function automatic logic jk_mode_legal(input jk_mode_t mode);
    return mode <= JK_MODE_CNT_DN;
  endfunction

endpackage

// File: rtl/jk_flop_bank_if.sv
// Control/status bundle between a bank user (master) and the flop bank (slave).
interface jk_flop_bank_if #(
  parameter int unsigned WIDTH = 8
);
  import jk_pkg::*;

  logic             en;
  jk_mode_t         mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qnot;
  logic             tc;
  logic [WIDTH-1:0] sr_err;

  modport master (
    output en, mode, j, k, load, load_val, err_clr,
    input  q, qnot, tc, sr_err
  );

  modport slave (
    input  en, mode, j, k, load, load_val, err_clr,
    output q, qnot, tc, sr_err
  );

endinterface

// File: rtl/jk_cell.sv
// Single-bit next-state function for every bank mode; no state of its own.
module jk_cell
  import jk_pkg::*;
(
  input  logic     q,
  input  logic     j,
  input  logic     k,
  input  jk_mode_t mode,
  input  logic     cnt_tog,
  output logic     q_next,
  output logic     sr_conflict
);

  always_comb begin
    q_next      = q;
    sr_conflict = (mode == JK_MODE_SR) && j && k;
    case (mode)
      JK_MODE_JK: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      JK_MODE_D: q_next = j;
      JK_MODE_T: q_next = q ^ j;
      JK_MODE_SR: begin
        // 11 is the forbidden SR pair: hold and let the top flag it.
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: q_next = q;
        endcase
      end
      JK_MODE_CNT_UP,
      JK_MODE_CNT_DN: q_next = q ^ cnt_tog;
      default:        q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_flop_bank.sv
// Bank of WIDTH JK-style flops with runtime mode, parallel load, terminal count
// and sticky SR-conflict flags.
module jk_flop_bank
  import jk_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              reset,
  jk_flop_bank_if.slave    bus
);

  logic [WIDTH-1:0] q_r, q_d;
  logic [WIDTH-1:0] err_r, err_d;
  logic             tc_r, tc_d;
  logic [WIDTH-1:0] up_tog, dn_tog, cnt_tog;
  logic [WIDTH-1:0] q_next, conflict;
  logic             upd, wrap;

  // Ripple toggle conditions: carry for counting up, borrow for counting down.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    if (i == 0) begin : g_lsb
      assign up_tog[i] = 1'b1;
      assign dn_tog[i] = 1'b1;
    end else begin : g_upper
      assign up_tog[i] = &q_r[i-1:0];
      assign dn_tog[i] = ~|q_r[i-1:0];
    end
  end

  assign cnt_tog = (bus.mode == JK_MODE_CNT_DN) ? dn_tog : up_tog;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .q           (q_r[i]),
      .j           (bus.j[i]),
      .k           (bus.k[i]),
      .mode        (bus.mode),
      .cnt_tog     (cnt_tog[i]),
      .q_next      (q_next[i]),
      .sr_conflict (conflict[i])
    );
  end

  assign upd  = bus.en && !bus.load && jk_mode_legal(bus.mode);
  assign wrap = ((bus.mode == JK_MODE_CNT_UP) && (&q_r)) ||
                ((bus.mode == JK_MODE_CNT_DN) && (~|q_r));

  // Next-state selection: load beats mode-driven update beats hold.
  always_comb begin
    q_d  = q_r;
    tc_d = 1'b0;
    if (bus.load) begin
      q_d = bus.load_val;
    end else if (upd) begin
      q_d  = q_next;
      tc_d = wrap;
    end
    // A new conflict on the same edge as err_clr survives the clear.
    err_d = (bus.err_clr ? '0 : err_r) | (conflict & {WIDTH{upd}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r   <= RESET_VAL;
      tc_r  <= 1'b0;
      err_r <= '0;
    end else begin
      q_r   <= q_d;
      tc_r  <= tc_d;
      err_r <= err_d;
    end
  end

  assign bus.q      = q_r;
  assign bus.qnot   = ~q_r;
  assign bus.tc     = tc_r;
  assign bus.sr_err = err_r;

endmodule
